// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Control sequencer for the 64-bit fetch datapath. It resolves B, CBZ and
//   B.cond at decode and drives the branch selectors (uncondBr, brTaken). It
//   also drives the PC and IF/ID enables, applies load-use stalls, squashes
//   wrong-path fetches for FLUSH_CYCLES cycles after a taken branch, holds the
//   NZVC flags, and counts taken branches.
//
// Parameters
//   FLUSH_CYCLES  cycles ifidFlush is held per taken branch (1..4)
//   CNT_W         width of the saturating taken-branch counter
//
// Ports
//   clk, reset                 clock, async active-high reset
//   instrValid                 decode-stage instruction is real
//   isB / isCBZ / isBcond      decoded branch type
//   cond                       B.cond condition field
//   regZero                    CBZ operand is zero
//   flagWrite, aluFlags        EX flag update {N,Z,V,C}
//   stallReq                   load-use hazard (level)
//   haltReq                    halt request
//   pcWrEn, ifidWrEn           PC and IF/ID write enables
//   ifidFlush                  load NOP into IF/ID
//   uncondBr, brTaken          branch target / PC mux selects
//   flags                      registered {N,Z,V,C}
//   takenCount                 saturating count of taken branches
module fetch_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instrValid,
  input  logic             isB,
  input  logic             isCBZ,
  input  logic             isBcond,
  input  logic [3:0]       cond,
  input  logic             regZero,
  input  logic             flagWrite,
  input  logic [3:0]       aluFlags,
  input  logic             stallReq,
  input  logic             haltReq,
  output logic             pcWrEn,
  output logic             ifidWrEn,
  output logic             ifidFlush,
  output logic             uncondBr,
  output logic             brTaken,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] takenCount
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] flushCnt;
  logic [3:0] evalFlags;
  logic       condTrue;
  logic       take;
  logic       flagN, flagZ, flagV, flagC;

  // A flag-setting instruction in EX in the same cycle as a B.cond in decode
  // must be seen by that B.cond, so the incoming ALU flags bypass the register.
  assign evalFlags = flagWrite ? aluFlags : flags;
  assign {flagN, flagZ, flagV, flagC} = evalFlags;

  // ARMv8 condition-code evaluation on the (possibly bypassed) flags.
  always_comb begin
    condTrue = 1'b0;
    case (cond)
      4'h0: condTrue = flagZ;
      4'h1: condTrue = ~flagZ;
      4'h2: condTrue = flagC;
      4'h3: condTrue = ~flagC;
      4'h4: condTrue = flagN;
      4'h5: condTrue = ~flagN;
      4'h6: condTrue = flagV;
      4'h7: condTrue = ~flagV;
      4'h8: condTrue = flagC & ~flagZ;
      4'h9: condTrue = ~flagC | flagZ;
      4'hA: condTrue = (flagN == flagV);
      4'hB: condTrue = (flagN != flagV);
      4'hC: condTrue = ~flagZ & (flagN == flagV);
      4'hD: condTrue = flagZ | (flagN != flagV);
      default: condTrue = 1'b1;
    endcase
  end

  assign take = instrValid & (isB | (isCBZ & regZero) | (isBcond & condTrue));

  // Control outputs are decoded from the current state and the decode-stage
  // inputs. While reset is high every output is forced low, so the fetch
  // datapath stays frozen without waiting for a clock edge.
  always_comb begin
    pcWrEn    = 1'b0;
    ifidWrEn  = 1'b0;
    ifidFlush = 1'b0;
    uncondBr  = 1'b0;
    brTaken   = 1'b0;
    if (!reset) begin
      uncondBr = isB;
      case (state)
        RUN: begin
          if (haltReq || stallReq) begin
            pcWrEn   = 1'b0;
            ifidWrEn = 1'b0;
          end else if (take) begin
            brTaken   = 1'b1;
            pcWrEn    = 1'b1;
            ifidWrEn  = 1'b1;
            ifidFlush = 1'b1;
          end else begin
            pcWrEn   = 1'b1;
            ifidWrEn = 1'b1;
          end
        end
        FLUSH: begin
          // A halt arriving mid-flush wins at once; otherwise keep squashing.
          if (!haltReq) begin
            pcWrEn    = 1'b1;
            ifidWrEn  = 1'b1;
            ifidFlush = 1'b1;
          end
        end
        default: begin
          pcWrEn = 1'b0;
        end
      endcase
    end
  end

  // State, flag register, flush countdown and taken-branch counter. The
  // counter only advances when a branch is actually redirected in RUN, and it
  // sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      flags      <= 4'b0000;
      flushCnt   <= 3'd0;
      takenCount <= '0;
    end else begin
      if (flagWrite && state != HALT) begin
        flags <= aluFlags;
      end
      case (state)
        RUN: begin
          if (haltReq) begin
            state <= HALT;
          end else if (!stallReq && take) begin
            if (takenCount != {CNT_W{1'b1}}) begin
              takenCount <= takenCount + CNT_W'(1);
            end
            if (FLUSH_CYCLES > 1) begin
              state    <= FLUSH;
              flushCnt <= 3'(FLUSH_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          if (haltReq) begin
            state    <= HALT;
            flushCnt <= 3'd0;
          end else begin
            flushCnt <= flushCnt - 3'd1;
            if (flushCnt == 3'd1) begin
              state <= RUN;
            end
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule
